fir_pipe: RTL and testbench
===========================

Name: fir_pipe

Overview:
Parametrised, fully pipelined direct-form FIR filter with run-time loadable coefficients and valid/ready streaming on input and output. Successor to the fixed 8-tap, 16-bit FIR in Signal_Processing_Architectures. Adds configurable tap count and widths, a registered adder tree, rounding, saturation and backpressure. It sits between a sample source and any downstream DSP stage that can stall.

Parameters:
WIDTH, 16, input sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 8, number of taps, 2..64
FRAC, 12, fractional bits dropped from the full-precision sum (Q-format shift)
OUT_W, 16, output width (signed)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
x_in  in  WIDTH  input sample
in_valid  in  1  x_in valid
in_ready  out  1  filter can accept a sample this cycle
y_out  out  OUT_W  filtered output sample
out_valid  out  1  y_out valid
out_ready  in  1  downstream accepts y_out
sat  out  1  y_out of current valid output was clipped
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  tap index, 0 = newest sample
coef_data  in  COEF_W  coefficient value
coef_ready  out  1  coefficient write will be accepted
flush  in  1  synchronous clear of delay line and pipeline

Behaviour:
- Reset (rst_n low, async):
  - delay line, coefficient bank, all pipeline registers and valid bits cleared to 0.
  - out_valid=0, y_out=0, sat=0.
  - in_ready=1, coef_ready=1 once rst_n is high.
- Stall: stall = out_valid & ~out_ready. When stall is high, every pipeline register and valid bit holds. in_ready = ~stall.
- Accept: sample accepted on an edge where in_valid & in_ready.
  - The delay line shifts only on accept: tap0 <= x_in, tap k <= tap k-1.
  - Non-accept cycles do not shift the delay line.
- Pipeline, ACC_W = WIDTH+COEF_W+clog2(TAPS):
  - stage M registers the TAPS products tap_k*coef_k, each full width.
  - clog2(TAPS) registered binary adder-tree levels, sign-extended to ACC_W. Non-power-of-2 TAPS is zero-padded.
  - stage R: add 2^(FRAC-1), arithmetic shift right by FRAC, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat=1 if clipped; sat is registered alongside y_out.
- Latency: with no stall, a sample accepted at edge t gives out_valid=1 after edge t+LAT, LAT = clog2(TAPS)+2 (5 for TAPS=8). Throughput is one sample per clock.
- Valid bits travel with the data and advance only when not stalled. Output handshake completes on out_valid & out_ready.
- Coefficients:
  - coef_ready = 1 when no valid bit is set in any pipeline stage and in_valid=0 this cycle.
  - A write with coef_we & coef_ready updates coef[coef_addr] at the edge.
  - A write with coef_ready=0 is ignored; no error flag.
  - coef_addr >= TAPS is ignored.
- Simultaneous events:
  - coef_we and in_valid in the same cycle: coef_ready is 0, so the sample wins and the write is dropped.
  - flush has priority over accept: it zeroes the delay line and all valid bits, and out_valid falls next edge. Coefficients are retained.
- Reset mid-operation: in-flight samples are discarded, coefficients are zeroed and must be reloaded.
- Outputs are registered; no combinational path from x_in to y_out. in_ready depends combinationally on out_ready.

Decomposition:
- Package fir_pipe_pkg holds:
  - clog2 function
  - ACC_W and LAT derivation functions
  - round/saturate function taking (acc, FRAC, OUT_W)
- Sub-module fir_add_tree: parametrised registered adder tree with valid and enable, instantiated once.

Test Plan:
- Impulse: load coefs {FEA8,FF18,02EC,068A,068A,02EC,FF18,FEA8}, feed 0x1000 then zeros, out_ready=1 -> y_out sequence FEA8,FF18,02EC,068A,068A,02EC,FF18,FEA8 then 0. The first output appears 5 cycles after accept; sat=0 throughout.
- Saturation: all coefs 0x7FFF, stream 0x7FFF -> once the delay line is full, y_out=0x7FFF with sat=1. Stream 0x8000 -> y_out=0x8000 with sat=1.
- Backpressure: hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during stall, y_out stable, no samples lost or duplicated against a software model.
- Coef gating: coef_we during an active stream -> coef_ready=0 and the coefficient is unchanged. After the pipeline drains, the write is accepted and the impulse response reflects the new value.
- Flush: assert flush with 3 samples in flight -> out_valid=0 on the next edge. A following 0x1000 impulse yields a clean coefficient sequence with no residue.
- Async reset mid-stream: rst_n low between edges -> out_valid, y_out and sat go to 0 immediately. After release, an impulse gives all-zero output until coefficients are reloaded.

Source files
------------

// File: rtl/fir_pipe_pkg.sv
// fir_pipe_pkg: shared helpers for the pipelined FIR.
//   clog2       - ceiling log2, used for address width and tree depth
//   acc_width   - accumulator width needed to hold a full-precision tap sum
//   latency     - accept-to-output latency in clocks
//   round_sat   - round-half-up, drop fractional bits, clip to a signed range
package fir_pipe_pkg;

    // Working width for rounding/saturation; comfortably wider than any
    // legal accumulator so the rounding add can never overflow.
    localparam int RS_W = 128;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int width, input int coef_w, input int taps);
        return width + coef_w + clog2(taps);
    endfunction

    function automatic int latency(input int taps);
        return clog2(taps) + 2;
    endfunction

    // Returns the rounded, shifted and clipped value sign-extended to RS_W;
    // callers keep the low out_w bits. clipped reports saturation.
    function automatic logic signed [RS_W-1:0] round_sat(
        input  logic signed [RS_W-1:0] acc,
        input  int                     frac,
        input  int                     out_w,
        output logic                   clipped
    );
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] rounded;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        one     = {{(RS_W-1){1'b0}}, 1'b1};
        rounded = (frac > 0) ? (acc + (one <<< (frac - 1))) : acc;
        rounded = rounded >>> frac;
        hi      = (one <<< (out_w - 1)) - one;
        lo      = -(one <<< (out_w - 1));
        clipped = 1'b0;
        if (rounded > hi) begin
            clipped = 1'b1;
            return hi;
        end else if (rounded < lo) begin
            clipped = 1'b1;
            return lo;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/fir_pipe_add_tree.sv
// fir_add_tree: registered binary adder tree.
//   N inputs of IN_W bits (signed, packed into din), sign-extended to OUT_W
//   and summed over clog2(N) register levels. Missing leaves of a
//   non-power-of-2 N are zero.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                advance all levels (held low while downstream stalls)
//   clr               synchronous clear of the valid bits
//   in_valid, din     operands for the first level
//   sum, out_valid    result of the last level
//   busy              any level holds a valid operand
module fir_add_tree
    import fir_pipe_pkg::*;
#(
    parameter int N     = 8,
    parameter int IN_W  = 32,
    parameter int OUT_W = 35
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [N*IN_W-1:0]   din,
    output logic [OUT_W-1:0]    sum,
    output logic                out_valid,
    output logic                busy
);

    localparam int LEVELS = clog2(N);
    localparam int P      = 1 << LEVELS;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = P >> l;
        logic signed [OUT_W-1:0] node [CNT];
        logic                    vld;
        logic                    busy_acc;

        if (l == 0) begin : g_in
            for (genvar i = 0; i < CNT; i++) begin : g_leaf
                if (i < N) begin : g_used
                    assign node[i] = {{(OUT_W-IN_W){din[i*IN_W+IN_W-1]}}, din[i*IN_W +: IN_W]};
                end else begin : g_pad
                    assign node[i] = '0;
                end
            end
            assign vld      = in_valid;
            assign busy_acc = 1'b0;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < CNT; i++) node[i] <= '0;
                    vld <= 1'b0;
                end else if (clr) begin
                    vld <= 1'b0;
                end else if (en) begin
                    for (int i = 0; i < CNT; i++)
                        node[i] <= g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
                    vld <= g_lvl[l-1].vld;
                end
            end
            assign busy_acc = g_lvl[l-1].busy_acc | vld;
        end
    end

    assign sum       = g_lvl[LEVELS].node[0];
    assign out_valid = g_lvl[LEVELS].vld;
    assign busy      = g_lvl[LEVELS].busy_acc;

endmodule

// File: rtl/fir_pipe.sv
// fir_pipe: pipelined direct-form FIR with loadable coefficients and
// valid/ready streaming on both sides.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   x_in, in_valid, in_ready    sample input handshake
//   y_out, out_valid, out_ready filtered output handshake
//   sat                         current y_out was clipped
//   coef_we, coef_addr,
//   coef_data, coef_ready       coefficient write port (tap 0 = newest)
//   flush                       clear delay line and in-flight samples
// Pipeline: delay line -> product regs -> adder tree -> round/saturate.
module fir_pipe
    import fir_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int FRAC   = 12,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         x_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         y_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat,
    input  logic                     coef_we,
    input  logic [clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     coef_ready,
    input  logic                     flush
);

    localparam int ACC_W = acc_width(WIDTH, COEF_W, TAPS);
    localparam int PW    = WIDTH + COEF_W;

    logic signed [WIDTH-1:0]  tap  [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [TAPS*PW-1:0]       prod;
    logic                     d_vld;
    logic                     m_vld;
    logic                     stall;
    logic                     accept;
    logic                     addr_ok;
    logic signed [ACC_W-1:0]  tree_sum;
    logic                     tree_vld;
    logic                     tree_busy;
    logic [OUT_W-1:0]         rs_y;
    logic                     rs_sat;

    assign stall      = out_valid & ~out_ready;
    assign in_ready   = ~stall;
    assign accept     = in_valid & in_ready;
    // Coefficients only change while nothing is in flight, so every output
    // is computed with one consistent coefficient set.
    assign coef_ready = ~(d_vld | m_vld | tree_busy | out_valid | in_valid);

    if (TAPS == (1 << clog2(TAPS))) begin : g_pow2
        assign addr_ok = 1'b1;
    end else begin : g_npow2
        assign addr_ok = (int'(coef_addr) < TAPS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) coef[k] <= '0;
        end else if (coef_we && coef_ready && addr_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Delay line shifts only on an accepted sample; flush wins over accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) tap[k] <= '0;
            d_vld <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) tap[k] <= '0;
            d_vld <= 1'b0;
        end else if (!stall) begin
            d_vld <= accept;
            if (accept) begin
                tap[0] <= x_in;
                for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            m_vld <= 1'b0;
        end else if (flush) begin
            m_vld <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < TAPS; k++)
                prod[k*PW +: PW] <= PW'(tap[k]) * PW'(coef[k]);
            m_vld <= d_vld;
        end
    end

    fir_add_tree #(
        .N     (TAPS),
        .IN_W  (PW),
        .OUT_W (ACC_W)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (~stall),
        .clr       (flush),
        .in_valid  (m_vld),
        .din       (prod),
        .sum       (tree_sum),
        .out_valid (tree_vld),
        .busy      (tree_busy)
    );

    always_comb begin
        rs_sat = 1'b0;
        rs_y   = OUT_W'(round_sat(RS_W'(tree_sum), FRAC, OUT_W, rs_sat));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out     <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= tree_vld;
            if (tree_vld) begin
                y_out <= rs_y;
                sat   <= rs_sat;
            end
        end
    end

endmodule

// File: tb/tb_fir_pipe.sv
module tb_fir_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] x_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_out;
    logic        out_valid;
    logic        out_ready;
    logic        sat;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data;
    logic        coef_ready;
    logic        flush;

    always #5 clk = ~clk;

    fir_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_in       (x_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y_out      (y_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat        (sat),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .flush      (flush)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          first_out;
    int          t_acc;
    logic [15:0] m_tap  [8];
    logic [15:0] m_coef [8];
    logic [16:0] exp_q  [$];
    logic [15:0] obs_y  [$];
    logic        obs_s  [$];
    logic [15:0] imp_c  [8] = '{16'hFEA8, 16'hFF18, 16'h02EC, 16'h068A,
                                16'h068A, 16'h02EC, 16'hFF18, 16'hFEA8};
    logic [15:0] c2     [8];
    logic [15:0] zc     [8] = '{default: 16'h0000};
    logic [15:0] bp_x   [16];
    logic [15:0] y_hold;
    int          n_sent;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] fir_model();
        longint acc;
        acc = 0;
        for (int k = 0; k < 8; k++)
            acc += longint'(signed'(m_tap[k])) * longint'(signed'(m_coef[k]));
        acc = (acc + 2048) >>> 12;
        if (acc > 32767)  return {1'b1, 16'h7FFF};
        if (acc < -32768) return {1'b1, 16'h8000};
        return {1'b0, acc[15:0]};
    endfunction

    // One clock: observe handshakes at the current inputs, update the model,
    // then advance to the next falling edge.
    task automatic step();
        logic [16:0] e;
        #1;
        if (out_valid && out_ready) begin
            obs_y.push_back(y_out);
            obs_s.push_back(sat);
            if (first_out < 0) first_out = cyc;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: observed y %h expected no output", y_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("y_model", 32'(y_out), 32'(e[15:0]));
                chk("sat_model", 32'(sat), 32'(e[16]));
            end
        end
        if (coef_we && coef_ready) m_coef[coef_addr] = coef_data;
        if (flush) begin
            for (int k = 0; k < 8; k++) m_tap[k] = '0;
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            for (int k = 7; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = x_in;
            exp_q.push_back(fir_model());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wr_coef(input int a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = d;
        step();
        coef_we   = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (coef_ready && exp_q.size() == 0) break;
            step();
        end
        chk("drain_idle", 32'(coef_ready), 32'd1);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_impulse(input int n, input bit gate);
        obs_y.delete();
        obs_s.delete();
        first_out = -1;
        in_valid  = 1'b1;
        x_in      = 16'h1000;
        step();
        t_acc = cyc;
        x_in  = 16'h0000;
        for (int i = 0; i < n; i++) begin
            if (gate && i == 1) begin
                coef_we   = 1'b1;
                coef_addr = 3'd3;
                coef_data = 16'h0100;
                #1;
                chk("coef_ready_stream", 32'(coef_ready), 32'd0);
            end
            step();
            coef_we = 1'b0;
        end
        if (gate) begin
            in_valid = 1'b0;
            #1;
            chk("coef_ready_busy", 32'(coef_ready), 32'd0);
        end
        drain();
        chk("imp_latency", 32'(first_out - t_acc), 32'd5);
    endtask

    task automatic chk_imp(input string tag, input logic [15:0] c [8]);
        chk({tag, "_count"}, 32'(obs_y.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < obs_y.size()) begin
                chk(tag, 32'(obs_y[i]), (i < 8) ? 32'(c[i]) : 32'd0);
                chk({tag, "_sat"}, 32'(obs_s[i]), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; x_in = '0; in_valid = 1'b0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; flush = 1'b0;
        first_out = -1;
        for (int k = 0; k < 8; k++) begin m_tap[k] = '0; m_coef[k] = '0; end

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y_out", 32'(y_out), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_coef_ready", 32'(coef_ready), 32'd1);
        @(negedge clk);

        // impulse, with a dropped coefficient write during the stream
        for (int k = 0; k < 8; k++) wr_coef(k, imp_c[k]);
        run_impulse(11, 1'b1);
        chk_imp("impulse", imp_c);

        // write accepted once drained
        wr_coef(3, 16'h0100);
        c2 = imp_c;
        c2[3] = 16'h0100;
        run_impulse(11, 1'b0);
        chk_imp("impulse_newcoef", c2);

        // backpressure
        for (int i = 0; i < 16; i++) bp_x[i] = 16'($urandom);
        obs_y.delete(); obs_s.delete();
        n_sent = 0;
        for (int c = 0; c < 24 && n_sent < 16; c++) begin
            out_ready = !(c >= 8 && c < 12);
            x_in      = bp_x[n_sent];
            in_valid  = 1'b1;
            #1;
            if (c >= 8 && c < 12) begin
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                if (c == 8) y_hold = y_out;
                else        chk("bp_y_stable", 32'(y_out), 32'(y_hold));
            end
            if (in_ready) n_sent++;
            step();
        end
        out_ready = 1'b1;
        drain();
        chk("bp_count", 32'(obs_y.size()), 32'd16);

        // flush with three samples in flight
        in_valid = 1'b1;
        x_in     = 16'h2000;
        repeat (3) step();
        flush = 1'b1;
        x_in  = 16'h7000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("flush_quiet", 32'(out_valid), 32'd0);
            step();
        end
        run_impulse(11, 1'b0);
        chk_imp("post_flush", c2);

        // async reset mid-stream
        in_valid = 1'b1;
        x_in     = 16'h1000;
        repeat (7) step();
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_y_out", 32'(y_out), 32'd0);
        chk("arst_sat", 32'(sat), 32'd0);
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin m_tap[k] = '0; m_coef[k] = '0; end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_impulse(11, 1'b0);
        chk_imp("post_rst_zero", zc);
        for (int k = 0; k < 8; k++) wr_coef(k, imp_c[k]);
        run_impulse(11, 1'b0);
        chk_imp("reload", imp_c);

        // saturation
        for (int k = 0; k < 8; k++) wr_coef(k, 16'h7FFF);
        obs_y.delete(); obs_s.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            x_in = (i < 12) ? 16'h7FFF : 16'h8000;
            step();
        end
        drain();
        chk("sat_count", 32'(obs_y.size()), 32'd24);
        if (obs_y.size() == 24) begin
            for (int i = 7; i < 12; i++) begin
                chk("sat_pos_y", 32'(obs_y[i]), 32'h7FFF);
                chk("sat_pos_flag", 32'(obs_s[i]), 32'd1);
            end
            for (int i = 19; i < 24; i++) begin
                chk("sat_neg_y", 32'(obs_y[i]), 32'h8000);
                chk("sat_neg_flag", 32'(obs_s[i]), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
